// File: rtl/path_delay_launcher.sv
// Launch/capture controller for a delay-test path: times rising (and optionally falling) path latency over
// a programmed number of trials. Optional falling-edge timing is enabled by defining PATH_DELAY_FALL_EN.
module path_delay_launcher #(
    parameter int TRIAL_W     = 8,
    parameter int LAT_W       = 8,
    parameter int SUM_W       = 16,
    parameter int TIMEOUT     = 200,
    parameter int SETTLE      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TRIAL_W-1:0] trials,
    output logic               path_in,
    input  logic               path_out,
    output logic               busy,
    output logic               done,
    output logic [LAT_W-1:0]   lat_min,
    output logic [LAT_W-1:0]   lat_max,
    output logic [SUM_W-1:0]   lat_sum,
    output logic [SUM_W-1:0]   fall_sum,
    output logic [TRIAL_W-1:0] timeout_n,
    output logic               stuck_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam int SET_W = $clog2(SETTLE + 1);

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] syncFf;
    logic                   synced;
    logic [SET_W-1:0]       settleCnt;
    logic [LAT_W-1:0]       latCnt;
    logic [LAT_W-1:0]       latency;
    logic [TRIAL_W-1:0]     trialCnt;
    logic [TRIAL_W-1:0]     trialsLatched;

    function automatic logic [SUM_W-1:0] satAdd(input logic [SUM_W-1:0] acc, input logic [LAT_W-1:0] inc);
        logic [SUM_W:0] total;
        total = {1'b0, acc} + (SUM_W+1)'(inc);
        return total[SUM_W] ? '1 : total[SUM_W-1:0];
    endfunction

    assign synced = syncFf[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) syncFf <= '0;
        else     syncFf <= {syncFf[SYNC_STAGES-2:0], path_out};
    end

`ifdef PATH_DELAY_FALL_EN
    logic             fallActive;
    logic [LAT_W-1:0] fallCnt;

    // Falling latency runs from the RETURN edge until the synchronised output drops, capped at SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fallActive <= 1'b0;
            fallCnt    <= '0;
            fall_sum   <= '0;
        end else if (state == ST_IDLE && start) begin
            fallActive <= 1'b0;
            fall_sum   <= '0;
        end else if (state == ST_RETURN) begin
            fallActive <= 1'b1;
            fallCnt    <= '0;
        end else if (state == ST_SETTLE && fallActive) begin
            if (!synced || settleCnt == SET_W'(SETTLE - 1)) begin
                fallActive <= 1'b0;
                fall_sum   <= satAdd(fall_sum, synced ? LAT_W'(SETTLE) : fallCnt);
            end else begin
                fallCnt <= fallCnt + LAT_W'(1);
            end
        end
    end
`else
    assign fall_sum = '0;
`endif

    // NOTE: every flop here holds control or result state, so all of them get the async reset; <= keeps updates race-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            path_in       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lat_min       <= '1;
            lat_max       <= '0;
            lat_sum       <= '0;
            timeout_n     <= '0;
            stuck_err     <= 1'b0;
            settleCnt     <= '0;
            latCnt        <= '0;
            latency       <= '0;
            trialCnt      <= '0;
            trialsLatched <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        trialsLatched <= trials;
                        trialCnt      <= '0;
                        settleCnt     <= '0;
                        lat_min       <= '1;
                        lat_max       <= '0;
                        lat_sum       <= '0;
                        timeout_n     <= '0;
                        stuck_err     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= (trials == '0) ? ST_FINISH : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    path_in   <= 1'b0;
                    settleCnt <= settleCnt + SET_W'(1);
                    if (settleCnt == SET_W'(SETTLE - 1)) begin
                        settleCnt <= '0;
                        if (synced) begin
                            stuck_err <= 1'b1;
                            state     <= ST_FINISH;
`ifdef PATH_DELAY_FALL_EN
                        end else if (trialCnt == trialsLatched) begin
                            state <= ST_FINISH;
`endif
                        end else begin
                            state <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    path_in <= 1'b1;
                    latCnt  <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The recorded count includes the synchroniser stages.
                    if (synced) begin
                        latency <= latCnt;
                        state   <= ST_RETURN;
                    end else if (latCnt == LAT_W'(TIMEOUT)) begin
                        latency   <= LAT_W'(TIMEOUT);
                        timeout_n <= timeout_n + TRIAL_W'(1);
                        state     <= ST_RETURN;
                    end else begin
                        latCnt <= latCnt + LAT_W'(1);
                    end
                end
                ST_RETURN: begin
                    path_in  <= 1'b0;
                    trialCnt <= trialCnt + TRIAL_W'(1);
                    lat_sum  <= satAdd(lat_sum, latency);
                    if (latency < lat_min) lat_min <= latency;
                    if (latency > lat_max) lat_max <= latency;
`ifdef PATH_DELAY_FALL_EN
                    state <= ST_SETTLE;
`else
                    state <= (trialCnt + TRIAL_W'(1) == trialsLatched) ? ST_FINISH : ST_SETTLE;
`endif
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
